nanov_spi_ram: RTL and testbench

SPI memory responder that serves the nanoV CPU's SPI master port in simulation and FPGA test harnesses. It decodes the CPU's serial command/address/data stream, returns read data on its MISO line, and stores write data in an internal byte array. It sits on the far side of the CPU's `spi_select`/`spi_out`/`spi_clk_enable`/`spi_data_in` wires and shares the CPU clock. A byte-wide load port lets the bench preload the memory.

---
 rtl/nanov_spi_ram.sv | 186 ++++++++++++++++++
 tb/tb_nanov_spi_ram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_ram.sv
// SPI memory responder for the nanoV CPU's SPI master port.
// Decodes read (0x03) and write (0x02) commands with a 24-bit address,
// serves read data on spi_miso and stores write data in a byte array.
// A backdoor load port allows preloading the memory.
module nanov_spi_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_select,
  input  logic                 spi_clk_enable,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 cmd_error
);

  localparam int MEM_BYTES = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    READ_ADDR,
    WRITE_ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t               r_state;
  logic [4:0]           r_bitCnt;
  logic [7:0]           r_shift;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_miso;
  logic                 r_cmdError;
  logic [7:0]           r_mem [0:MEM_BYTES-1];

  state_t               w_state;
  logic [4:0]           w_bitCnt;
  logic [7:0]           w_shift;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_miso;
  logic                 w_cmdError;
  logic                 w_spiWe;
  logic [7:0]           w_wrByte;
  logic [ADDR_BITS-1:0] w_addrShift;
  logic [ADDR_BITS-1:0] w_addrInc;

  // Only the low ADDR_BITS of the 24-bit address survive the shift, so
  // upper address bits alias naturally.
  assign w_addrShift = {r_addr[ADDR_BITS-2:0], spi_mosi};
  assign w_addrInc   = r_addr + ADDR_ONE;
  assign w_wrByte    = {r_shift[6:0], spi_mosi};

  assign spi_miso  = r_miso;
  assign busy      = (r_state != IDLE);
  assign cmd_error = r_cmdError;

  // Next-state and datapath decode; deselect overrides everything, and
  // edges without spi_clk_enable hold state (cmd_error still self-clears).
  always_comb begin
    w_state    = r_state;
    w_bitCnt   = r_bitCnt;
    w_shift    = r_shift;
    w_addr     = r_addr;
    w_miso     = r_miso;
    w_cmdError = 1'b0;
    w_spiWe    = 1'b0;
    if (spi_select) begin
      w_state  = IDLE;
      w_bitCnt = 5'd0;
      w_shift  = 8'd0;
      w_miso   = 1'b0;
    end else if (spi_clk_enable) begin
      case (r_state)
        IDLE: begin
          w_state  = CMD;
          w_shift  = w_wrByte;
          w_bitCnt = 5'd1;
        end
        CMD: begin
          w_shift = w_wrByte;
          if (r_bitCnt == 5'd7) begin
            w_bitCnt = 5'd0;
            w_shift  = 8'd0;
            case (w_wrByte)
              8'h03:   w_state = READ_ADDR;
              8'h02:   w_state = WRITE_ADDR;
              default: begin
                w_state    = IGNORE;
                w_cmdError = 1'b1;
              end
            endcase
          end else begin
            w_bitCnt = r_bitCnt + 5'd1;
          end
        end
        READ_ADDR: begin
          w_addr = w_addrShift;
          if (r_bitCnt == 5'd23) begin
            w_state  = READ;
            w_bitCnt = 5'd0;
            w_shift  = r_mem[w_addrShift];
            w_miso   = r_mem[w_addrShift][7];
          end else begin
            w_bitCnt = r_bitCnt + 5'd1;
          end
        end
        WRITE_ADDR: begin
          w_addr = w_addrShift;
          if (r_bitCnt == 5'd23) begin
            w_state  = WRITE;
            w_bitCnt = 5'd0;
            w_shift  = 8'd0;
          end else begin
            w_bitCnt = r_bitCnt + 5'd1;
          end
        end
        READ: begin
          if (r_bitCnt == 5'd7) begin
            w_addr   = w_addrInc;
            w_bitCnt = 5'd0;
            w_shift  = r_mem[w_addrInc];
            w_miso   = r_mem[w_addrInc][7];
          end else begin
            w_miso   = r_shift[6];
            w_shift  = {r_shift[6:0], 1'b0};
            w_bitCnt = r_bitCnt + 5'd1;
          end
        end
        WRITE: begin
          if (r_bitCnt == 5'd7) begin
            w_spiWe  = 1'b1;
            w_addr   = w_addrInc;
            w_bitCnt = 5'd0;
            w_shift  = 8'd0;
          end else begin
            w_shift  = w_wrByte;
            w_bitCnt = r_bitCnt + 5'd1;
          end
        end
        IGNORE: begin
          w_miso = 1'b0;
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_bitCnt   <= 5'd0;
      r_shift    <= 8'd0;
      r_addr     <= '0;
      r_miso     <= 1'b0;
      r_cmdError <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_bitCnt   <= w_bitCnt;
      r_shift    <= w_shift;
      r_addr     <= w_addr;
      r_miso     <= w_miso;
      r_cmdError <= w_cmdError;
    end
  end

  // Memory array, untouched by reset; a backdoor load beats an SPI write
  // committing to the same address on the same edge.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
    if (w_spiWe && !(load_en && (load_addr == r_addr))) begin
      r_mem[r_addr] <= w_wrByte;
    end
  end

endmodule

// File: tb/tb_nanov_spi_ram.sv
// Directed self-checking bench for nanov_spi_ram.
module tb_nanov_spi_ram;

  logic       clk;
  logic       rstn;
  logic       spi_select;
  logic       spi_clk_enable;
  logic       spi_mosi;
  logic       spi_miso;
  logic       load_en;
  logic [9:0] load_addr;
  logic [7:0] load_data;
  logic       busy;
  logic       cmd_error;

  int testsRun    = 0;
  int testsFailed = 0;

  logic        gapStable;
  logic [15:0] readWord;
  logic        busyAll;
  logic        misoZeroAll;

  nanov_spi_ram #(.ADDR_BITS(10)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .spi_select    (spi_select),
    .spi_clk_enable(spi_clk_enable),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .busy          (busy),
    .cmd_error     (cmd_error)
  );

  // Free-running system clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One SPI bit edge, then gapCycles idle cycles with enable low while
  // watching that spi_miso holds its value.
  task automatic applyStimulus(input logic mosiBit, input int gapCycles);
    logic held;
    @(negedge clk);
    spi_select     = 1'b0;
    spi_clk_enable = 1'b1;
    spi_mosi       = mosiBit;
    @(posedge clk);
    #1;
    spi_clk_enable = 1'b0;
    held = spi_miso;
    for (int g = 0; g < gapCycles; g++) begin
      @(posedge clk);
      #1;
      if (spi_miso !== held) gapStable = 1'b0;
    end
  endtask

  // Shift a byte MSB first.
  task automatic sendByte(input logic [7:0] value, input int gapCycles);
    for (int i = 7; i >= 0; i--) applyStimulus(value[i], gapCycles);
  endtask

  // Shift a 24-bit address MSB first.
  task automatic sendAddr(input logic [23:0] value, input int gapCycles);
    for (int i = 23; i >= 0; i--) applyStimulus(value[i], gapCycles);
  endtask

  // Raise chip select for one edge.
  task automatic deselect();
    @(negedge clk);
    spi_select     = 1'b1;
    spi_clk_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Backdoor byte write.
  task automatic loadByte(input logic [9:0] addr, input logic [7:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  // Read two bytes over SPI, capturing what the CPU would sample at each
  // of the 16 bit edges after the address.
  task automatic readTwo(input logic [23:0] addr, input int gapCycles);
    busyAll = 1'b1;
    sendByte(8'h03, gapCycles);
    sendAddr(addr, gapCycles);
    for (int i = 15; i >= 0; i--) begin
      readWord[i] = spi_miso;
      if (busy !== 1'b1) busyAll = 1'b0;
      applyStimulus(1'b0, gapCycles);
    end
    if (busy !== 1'b1) busyAll = 1'b0;
    deselect();
  endtask

  // Directed test sequence.
  initial begin
    rstn           = 1'b0;
    spi_select     = 1'b1;
    spi_clk_enable = 1'b0;
    spi_mosi       = 1'b0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = '0;
    gapStable      = 1'b1;
    readWord       = '0;
    busyAll        = 1'b0;
    misoZeroAll    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("reset_miso", {15'd0, spi_miso}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_cmd_error", {15'd0, cmd_error}, 16'd0);

    // Preloads used by several tests.
    loadByte(10'h010, 8'hA5);
    loadByte(10'h011, 8'h3C);
    loadByte(10'h3FF, 8'h11);
    loadByte(10'h000, 8'h22);
    loadByte(10'h001, 8'h5A);

    // Basic read.
    readTwo(24'h000010, 0);
    checkOutput("read_bits", readWord, 16'hA53C);
    checkOutput("read_busy", {15'd0, busyAll}, 16'd1);
    checkOutput("read_busy_after_deselect", {15'd0, busy}, 16'd0);

    // Basic write then read back.
    sendByte(8'h02, 0);
    sendAddr(24'h000020, 0);
    sendByte(8'hDE, 0);
    sendByte(8'hAD, 0);
    checkOutput("write_busy", {15'd0, busy}, 16'd1);
    deselect();
    checkOutput("write_busy_after_deselect", {15'd0, busy}, 16'd0);
    readTwo(24'h000020, 0);
    checkOutput("write_readback", readWord, 16'hDEAD);

    // Address wrap and upper-bit aliasing.
    readTwo(24'h0003FF, 0);
    checkOutput("wrap_read", readWord, 16'h1122);
    readTwo(24'h001010, 0);
    checkOutput("alias_read", readWord, 16'hA53C);

    // Enable gaps of three cycles between every bit.
    gapStable = 1'b1;
    readTwo(24'h000010, 3);
    checkOutput("gap_read", readWord, 16'hA53C);
    checkOutput("gap_miso_stable", {15'd0, gapStable}, 16'd1);
    checkOutput("gap_busy", {15'd0, busyAll}, 16'd1);

    // Partial write byte is discarded on deselect.
    sendByte(8'h02, 0);
    sendAddr(24'h000000, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0);
    deselect();
    readTwo(24'h000000, 0);
    checkOutput("abort_write_mem0", readWord, 16'h225A);

    // Load and SPI write collide on the same address: load wins, the
    // address still advances for the next SPI byte.
    sendByte(8'h02, 0);
    sendAddr(24'h000030, 0);
    for (int i = 7; i >= 1; i--) applyStimulus(i[0] ^ 1'b1 ? 1'b1 : 1'b1, 0);
    @(negedge clk);
    spi_clk_enable = 1'b1;
    spi_mosi       = 1'b1;
    load_en        = 1'b1;
    load_addr      = 10'h030;
    load_data      = 8'h99;
    @(posedge clk);
    #1;
    spi_clk_enable = 1'b0;
    load_en        = 1'b0;
    sendByte(8'h66, 0);
    deselect();
    readTwo(24'h000030, 0);
    checkOutput("load_wins_collision", readWord, 16'h9966);

    // Reset in the middle of a read.
    sendByte(8'h03, 0);
    sendAddr(24'h000010, 0);
    checkOutput("pre_reset_miso", {15'd0, spi_miso}, 16'd1);
    checkOutput("pre_reset_busy", {15'd0, busy}, 16'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_miso", {15'd0, spi_miso}, 16'd0);
    checkOutput("async_reset_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    spi_select = 1'b1;
    rstn       = 1'b1;

    // Unsupported command.
    sendByte(8'h9F, 0);
    checkOutput("bad_cmd_error_set", {15'd0, cmd_error}, 16'd1);
    @(posedge clk);
    #1;
    checkOutput("bad_cmd_error_clear", {15'd0, cmd_error}, 16'd0);
    misoZeroAll = 1'b1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 0);
      if (spi_miso !== 1'b0) misoZeroAll = 1'b0;
    end
    checkOutput("bad_cmd_miso_zero", {15'd0, misoZeroAll}, 16'd1);
    checkOutput("bad_cmd_busy", {15'd0, busy}, 16'd1);
    deselect();
    readTwo(24'h000010, 0);
    checkOutput("bad_cmd_mem_unchanged", readWord, 16'hA53C);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
